// File: rtl/mazegen_pkg.sv
// Shared types and default geometry for the maze generator bitmap blocks.
package mazegen_pkg;

    localparam int unsigned BitmapNloc  = 1024;
    localparam int unsigned BitmapDbits = 12;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } writer_state_e;

endpackage

// File: rtl/bitmap_ram.sv
// Writable bitmap memory: synchronous write, registered read.
module bitmap_ram
    import mazegen_pkg::*;
#(
    parameter int unsigned Nloc  = BitmapNloc,
    parameter int unsigned Dbits = BitmapDbits
) (
    input  logic                    clock,
    input  logic                    wr,
    input  logic [$clog2(Nloc)-1:0] addr,
    input  logic [Dbits-1:0]        din,
    output logic [Dbits-1:0]        dout
);

    logic [Dbits-1:0] mem [Nloc];

    always_ff @(posedge clock) begin
        if (wr) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/bitmap_writer.sv
// Write port for the bitmap memory: single writes from a ready/valid request stream
// plus a whole-memory fill command that runs one write per cycle.
module bitmap_writer
    import mazegen_pkg::*;
#(
    parameter int unsigned Nloc  = BitmapNloc,
    parameter int unsigned Dbits = BitmapDbits
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [$clog2(Nloc)-1:0] req_addr,
    input  logic [Dbits-1:0]        req_data,
    input  logic                    clear_start,
    input  logic [Dbits-1:0]        clear_data,
    output logic                    wr,
    output logic [$clog2(Nloc)-1:0] addr,
    output logic [Dbits-1:0]        din,
    output logic                    busy,
    output logic                    done,
    output logic                    err_oor
);

    localparam int unsigned AW = $clog2(Nloc);
    // One extra bit so a non power-of-two Nloc compares without wrapping.
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] LastIdx = CW'(Nloc - 1);
    localparam logic [CW-1:0] NlocC   = CW'(Nloc);

    writer_state_e    state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [Dbits-1:0] fill_q, fill_d;
    logic             wr_q, wr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [Dbits-1:0] din_q, din_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic          accept;
    logic          in_range;
    logic [CW-1:0] cnt_inc;

    assign req_ready = (state_q == StIdle) && !clear_start;
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < NlocC;
    assign cnt_inc   = cnt_q + CW'(1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            fill_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (clear_start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The output registers always hold the write for the current cycle, so the
    // counter equals the address presented on the bus while in StClear.
    always_comb begin
        cnt_d  = cnt_q;
        fill_d = fill_q;
        wr_d   = 1'b0;
        addr_d = addr_q;
        din_d  = din_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (clear_start) begin
                    cnt_d  = '0;
                    fill_d = clear_data;
                    wr_d   = 1'b1;
                    addr_d = '0;
                    din_d  = clear_data;
                    done_d = (LastIdx == '0);
                end else if (accept) begin
                    if (in_range) begin
                        wr_d   = 1'b1;
                        addr_d = req_addr;
                        din_d  = req_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StClear: begin
                if (cnt_q != LastIdx) begin
                    cnt_d  = cnt_inc;
                    wr_d   = 1'b1;
                    addr_d = cnt_inc[AW-1:0];
                    din_d  = fill_q;
                    done_d = (cnt_inc == LastIdx);
                end
            end
            default: ;
        endcase
    end

    assign wr      = wr_q;
    assign addr    = addr_q;
    assign din     = din_q;
    assign busy    = (state_q == StClear);
    assign done    = done_q;
    assign err_oor = err_q;

endmodule

// File: doc/bitmap_writer.md
BITMAP_WRITER -- requirements
Module: bitmap_writer

Interface
REQ-001 SHALL have parameter Nloc, default 1024, meaning the number of target memory locations.
REQ-002 SHALL have parameter Dbits, default 12, meaning the data width per location.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on posedge clock.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  write request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both 1.
REQ-007 SHALL have port req_addr  input  $clog2(Nloc)  target location of the request.
REQ-008 SHALL have port req_data  input  Dbits  value to write.
REQ-009 SHALL have port clear_start  input  1  one-cycle command to fill the whole memory.
REQ-010 SHALL have port clear_data  input  Dbits  fill value, sampled when clear_start is accepted.
REQ-011 SHALL have port wr  output  1  memory write enable.
REQ-012 SHALL have port addr  output  $clog2(Nloc)  memory address.
REQ-013 SHALL have port din  output  Dbits  memory write data.
REQ-014 SHALL have port busy  output  1  high while a clear is in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a clear completes.
REQ-016 SHALL have port err_oor  output  1  one-cycle pulse when an accepted request has req_addr >= Nloc.

Function
REQ-017 SHALL implement the FSM states IDLE and CLEAR; IDLE serves single writes, CLEAR runs the fill.
REQ-018 SHALL drive wr, addr, din, done and err_oor from registers.
REQ-019 SHALL drive req_ready combinationally as (state==IDLE) and not clear_start.
REQ-020 SHALL, on an accepted request with req_addr < Nloc, assert wr=1, addr=req_addr and din=req_data in the next cycle only (latency 1).
REQ-021 SHALL sustain back-to-back requests at one write per cycle with no bubble.
REQ-022 SHALL, on an accepted request with req_addr >= Nloc, keep wr=0, pulse err_oor in the next cycle, and still complete the handshake.
REQ-023 SHALL move IDLE->CLEAR on clear_start in IDLE, latching clear_data and zeroing the fill counter.
REQ-024 SHALL, in CLEAR, issue wr=1, addr=counter and din=latched value every cycle for counter 0..Nloc-1, incrementing by 1 each cycle.
REQ-025 SHALL make a clear take exactly Nloc write cycles.
REQ-026 SHALL, after the write to Nloc-1, return to IDLE and pulse done for one cycle coincident with that last write.
REQ-027 SHALL hold busy=1 from the cycle after clear_start through the last clear write.
REQ-028 SHALL give clear_start priority when it coincides with req_valid in IDLE; the request is not accepted that cycle.
REQ-029 SHALL ignore clear_start while in CLEAR.
REQ-030 SHALL hold req_ready=0 throughout CLEAR.
REQ-031 SHALL size the fill counter at $clog2(Nloc)+1 bits so that Nloc values that are not a power of two terminate correctly, with no wrap.
REQ-032 SHALL permit wr to go high on the first IDLE cycle after CLEAR if a request was accepted on the final CLEAR cycle; this cannot occur because req_ready=0 in CLEAR, so the first post-clear write comes no earlier than 2 cycles after done.

Reset
REQ-033 SHALL, while reset_n=0 at posedge clock, force state=IDLE, counter=0, wr=0, addr=0, din=0, busy=0, done=0 and err_oor=0.
REQ-034 SHALL make a reset during CLEAR abort the fill with no further writes and no done pulse.
REQ-035 SHALL make a request accepted in the cycle reset_n falls produce no write.

Structure
REQ-036 SHALL define the state enum typedef in shared package mazegen_pkg, alongside the default Nloc/Dbits constants also used by the read-only bitmap memory.
REQ-037 SHALL use no sub-module; the block is a single FSM plus counter, and the writable memory lives outside it.
REQ-038 SHALL have the bench instantiate a writable memory model, bitmap_ram, with ports clock/wr/addr/din/dout, for checking.

Verification
REQ-039 SHALL cover: reset, then req addr=5 data=12'hABC -> next cycle wr=1, addr=5, din=ABC; memory[5]=ABC.
REQ-040 SHALL cover: 4 back-to-back requests at addr 0..3 -> 4 consecutive wr cycles, req_ready stays 1.
REQ-041 SHALL cover: clear_start with clear_data=12'h000 and Nloc=1024 -> busy for 1024 cycles, done pulses once, all locations read 000.
REQ-042 SHALL cover: clear_start and req_valid in the same cycle -> req_ready=0, clear runs, request is held until after CLEAR, then written.
REQ-043 SHALL cover: Nloc=1000 and req addr=1010 -> err_oor pulses, wr stays 0, memory unchanged; a clear writes exactly 1000 locations.
REQ-044 SHALL cover: reset_n low at clear cycle 300 -> no write after reset, no done pulse, busy=0, req_ready=1 after reset releases.
